// File: rtl/alu_issue_regfile.sv
// rtl/alu_issue_regfile.sv - operand/issue stage with register file for an external 16-bit ALU
// Four-state issue loop: accept, read operands, let the ALU settle, write back.
module alu_issue_regfile #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16,
  parameter int FLAG_WIDTH = 5,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [7:0]            alu_opcode,
  input  logic [DATA_WIDTH-1:0] alu_c,
  input  logic [FLAG_WIDTH-1:0] alu_flags,
  output logic [FLAG_WIDTH-1:0] psr,
  output logic                  done,
  output logic                  illegal,
  input  logic [AW-1:0]         dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t                state_q;
  logic [15:0]           instr_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] alu_a_q, alu_b_q, c_q;
  logic [7:0]            alu_opcode_q;
  logic [FLAG_WIDTH-1:0] flags_q, psr_q;
  logic                  legal_q, write_q, done_q, illegal_q;

  logic [3:0]            op, ext;
  logic [7:0]            imm;
  logic [AW-1:0]         rd, rs;
  logic                  dec_legal, dec_write;
  logic [7:0]            dec_opcode;
  logic [DATA_WIDTH-1:0] dec_b;

  assign op  = instr_q[15:12];
  assign ext = instr_q[7:4];
  assign imm = instr_q[7:0];
  assign rd  = instr_q[8 +: AW];
  assign rs  = instr_q[0 +: AW];

  // The same six function codes are valid as opext (register form) and as op (immediate form).
  function automatic logic code_ok(input logic [3:0] code);
    return code inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB};
  endfunction

  always_comb begin
    dec_legal  = 1'b0;
    dec_write  = 1'b0;
    dec_opcode = 8'h00;
    dec_b      = regs_q[rs];
    if (op == 4'h0) begin
      if (code_ok(ext)) begin
        dec_legal  = 1'b1;
        dec_write  = (ext != 4'hB);
        dec_opcode = {4'h0, ext};
      end
    end else if (code_ok(op)) begin
      dec_legal  = 1'b1;
      dec_write  = (op != 4'hB);
      dec_opcode = {op, 4'h0};
      // Arithmetic immediates are signed; logical immediates are zero-extended.
      if (op inside {4'h5, 4'h9, 4'hB})
        dec_b = {{(DATA_WIDTH-8){imm[7]}}, imm};
      else
        dec_b = {{(DATA_WIDTH-8){1'b0}}, imm};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      instr_q      <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      c_q          <= '0;
      flags_q      <= '0;
      psr_q        <= '0;
      legal_q      <= 1'b0;
      write_q      <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state_q <= READ;
          end
        end
        READ: begin
          alu_a_q      <= regs_q[rd];
          alu_b_q      <= dec_b;
          alu_opcode_q <= dec_opcode;
          legal_q      <= dec_legal;
          write_q      <= dec_write;
          state_q      <= EXEC;
        end
        EXEC: begin
          c_q     <= alu_c;
          flags_q <= alu_flags;
          state_q <= WB;
        end
        WB: begin
          if (write_q) regs_q[rd] <= c_q;
          if (legal_q) psr_q <= flags_q;
          done_q    <= 1'b1;
          illegal_q <= ~legal_q;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_opcode  = alu_opcode_q;
  assign psr         = psr_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_regfile.sv
// tb/tb_alu_issue_regfile.sv - scoreboard bench for alu_issue_regfile with a behavioural ALU and register model
// Accepts are modelled as they happen; a monitor checks each retirement against the queued expectation.
module tb_alu_issue_regfile;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] alu_a, alu_b, alu_c, dbg_data;
  logic [7:0]  alu_opcode;
  logic [4:0]  alu_flags, psr;
  logic        done, illegal;
  logic [3:0]  dbg_addr, stim_addr = '0, mon_addr = '0;
  logic        mon_sel = 1'b0;

  assign dbg_addr = mon_sel ? mon_addr : stim_addr;

  alu_issue_regfile dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_c(alu_c), .alu_flags(alu_flags), .psr(psr), .done(done), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: returns {flags, result}.
  function automatic logic [20:0] alu_fn(input logic [7:0] opc, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] c;
    s = 17'h0;
    case (opc)
      8'h01, 8'h10: c = a & b;
      8'h02, 8'h20: c = a | b;
      8'h03, 8'h30: c = a ^ b;
      8'h05, 8'h50: begin s = {1'b0, a} + {1'b0, b}; c = s[15:0]; end
      8'h09, 8'h90, 8'h0B, 8'hB0: begin s = {1'b0, a} - {1'b0, b}; c = s[15:0]; end
      default: c = a ^ 16'hA5A5;
    endcase
    return {s[16], (c == 16'h0), ($signed(a) < $signed(b)), c[15], (a < b), c};
  endfunction

  assign {alu_flags, alu_c} = alu_fn(alu_opcode, alu_a, alu_b);

  typedef struct packed {
    logic        ill;
    logic [7:0]  opc;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  rd;
    logic [15:0] rv;
    logic [4:0]  psr;
    logic [31:0] acc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_regs [16];
  logic [4:0]  m_psr = '0;
  int          checks = 0, failures = 0;
  int          acc_cnt = 0, done_cnt = 0, flushed = 0;
  logic [31:0] cyc = 0;
  logic [31:0] acc_cyc [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: apply the instruction-set rules directly to the architectural state.
  task automatic model_accept(input logic [15:0] w, input logic [31:0] at);
    int          op, ext, rd, rs;
    logic        legal, wr;
    logic [7:0]  opc;
    logic [15:0] a, b, c;
    logic [4:0]  f;
    exp_t        e;
    op = int'(w[15:12]); ext = int'(w[7:4]); rd = int'(w[11:8]); rs = int'(w[3:0]);
    a = m_regs[rd]; b = m_regs[rs]; legal = 1'b0; wr = 1'b0; opc = 8'h00;
    if (op == 0) begin
      if (ext inside {1, 2, 3, 5, 9, 11}) begin
        legal = 1'b1; wr = (ext != 11); opc = 8'(ext);
      end
    end else if (op inside {1, 2, 3, 5, 9, 11}) begin
      legal = 1'b1; wr = (op != 11); opc = 8'(op * 16);
      if (op >= 5) b = 16'($signed(w[7:0]));
      else         b = {8'h00, w[7:0]};
    end
    {f, c} = alu_fn(opc, a, b);
    if (legal) m_psr = f;
    if (wr) m_regs[rd] = c;
    e.ill = ~legal; e.opc = opc; e.a = a; e.b = b; e.rd = 4'(rd);
    e.rv = m_regs[rd]; e.psr = m_psr; e.acc = at;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      model_accept(instr, cyc);
      acc_cyc[acc_cnt % 2] = cyc;
      acc_cnt++;
    end
    cyc++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && illegal && !done) chk("illegal_without_done", 32'(illegal), 0);
    if (!reset && done) begin
      done_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(done), 0);
      end else begin
        e = q.pop_front();
        chk("latency_edges", cyc - e.acc, 4);
        chk("illegal", 32'(illegal), 32'(e.ill));
        chk("psr", 32'(psr), 32'(e.psr));
        chk("alu_opcode", 32'(alu_opcode), 32'(e.opc));
        if (!e.ill) begin
          chk("alu_a", 32'(alu_a), 32'(e.a));
          chk("alu_b", 32'(alu_b), 32'(e.b));
        end
        mon_addr = e.rd; mon_sel = 1'b1;
        #1;
        chk("rdest_value", 32'(dbg_data), 32'(e.rv));
        mon_sel = 1'b0;
      end
    end
  end

  task automatic issue(input logic [15:0] w);
    int n0, t;
    n0 = acc_cnt; t = 0;
    @(negedge clk);
    instr = w; instr_valid = 1'b1;
    while (acc_cnt == n0 && t < 20) begin @(negedge clk); t++; end
    instr_valid = 1'b0;
    if (acc_cnt == n0) chk("accept_timeout", 32'(acc_cnt), 32'(n0 + 1));
  endtask

  task automatic retire_wait();
    int t;
    t = 0;
    while (q.size() != 0 && t < 50) begin @(negedge clk); t++; end
    if (q.size() != 0) chk("retire_timeout", 32'(q.size()), 0);
    @(negedge clk);
    #2;
  endtask

  task automatic chk_reg(input string name, input logic [3:0] r, input logic [15:0] exp);
    stim_addr = r;
    #1;
    chk(name, 32'(dbg_data), 32'(exp));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    logic [4:0]  p0;
    int          n0, t, code, dc0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;

    #1;
    chk("reset_ready", 32'(instr_ready), 1);
    chk("reset_psr", 32'(psr), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_opcode", 32'(alu_opcode), 0);
    chk_reg("reset_r0", 4'd0, 16'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    issue(16'h517F); retire_wait();
    chk("addi_opcode", 32'(alu_opcode), 32'h50);
    chk("addi_b", 32'(alu_b), 32'h007F);
    issue(16'h5101); retire_wait();
    chk_reg("addi_r1", 4'd1, 16'h0080);

    issue(16'h92FF); retire_wait();
    chk("subi_b_sext", 32'(alu_b), 32'hFFFF);
    chk_reg("subi_r2", 4'd2, 16'h0001);
    issue(16'h12FF); retire_wait();
    chk("andi_b_zext", 32'(alu_b), 32'h00FF);

    issue(16'h2312);
    for (int i = 0; i < 8; i++) issue(16'h0353);
    issue(16'h2334);
    issue(16'h24FF); retire_wait();
    chk_reg("build_r3", 4'd3, 16'h1234);
    issue(16'h0334); retire_wait();
    chk("xor_opcode", 32'(alu_opcode), 32'h03);
    chk_reg("xor_r3", 4'd3, 16'h12CB);
    issue(16'h03B4); retire_wait();
    chk_reg("cmp_r3_kept", 4'd3, 16'h12CB);
    chk("cmp_psr", 32'(psr), 32'(alu_fn(8'h0B, 16'h12CB, 16'h00FF) >> 16));

    n0 = acc_cnt; t = 0;
    @(negedge clk);
    instr = 16'h5610; instr_valid = 1'b1;
    while (acc_cnt == n0 && t < 20) begin @(negedge clk); t++; end
    instr = 16'h0756;
    while (acc_cnt < n0 + 2 && t < 40) begin @(negedge clk); t++; end
    instr_valid = 1'b0;
    chk("b2b_accepts", 32'(acc_cnt - n0), 2);
    retire_wait();
    chk("b2b_spacing", acc_cyc[(n0 + 1) % 2] - acc_cyc[n0 % 2], 4);
    chk_reg("b2b_forward_r7", 4'd7, 16'h0010);

    issue(16'h5F55); retire_wait();
    p0 = psr;
    issue(16'hF000);
    issue(16'hFF00); retire_wait();
    chk_reg("illegal_r15", 4'd15, 16'h0055);
    chk("illegal_psr", 32'(psr), 32'(p0));

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) != 0) begin
        code = 0;
        case ($urandom_range(0, 5))
          0: code = 1; 1: code = 2; 2: code = 3; 3: code = 5; 4: code = 9; default: code = 11;
        endcase
        w = 16'($urandom);
        if ($urandom_range(0, 1) == 1) w[15:12] = 4'(code);
        else begin w[15:12] = 4'h0; w[7:4] = 4'(code); end
      end else begin
        w = 16'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          while (w[15:12] inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB}) w[15:12] = 4'($urandom);
        end else begin
          w[15:12] = 4'h0;
          while (w[7:4] inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB}) w[7:4] = 4'($urandom);
        end
      end
      issue(w);
    end
    retire_wait();

    issue(16'h5512); retire_wait();
    chk_reg("preload_r5", 4'd5, m_regs[5]);
    issue(16'h5503);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midexec_ready", 32'(instr_ready), 1);
    chk("midexec_psr", 32'(psr), 0);
    chk_reg("midexec_r5", 4'd5, 16'h0);
    flushed += q.size();
    q.delete();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_psr = '0;
    dc0 = done_cnt;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("no_done_after_reset", 32'(done_cnt), 32'(dc0));
    issue(16'h5501); retire_wait();
    chk_reg("post_reset_r5", 4'd5, 16'h0001);

    chk("queue_drained", 32'(q.size()), 0);
    chk("retire_count", 32'(done_cnt), 32'(acc_cnt - flushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
